if_fetch: RTL and testbench

Instruction-fetch stage for the 5-stage RISC-V pipeline; it is the producer side of the IF/ID register. It holds the PC, looks instructions up in a direct-mapped instruction cache, and fetches misses through the memory controller using a word-level request/done handshake. It also applies jump redirects from EX and raises a stall request to the stall controller while a miss is outstanding.

---
 rtl/if_fetch_pkg.sv | 19 +
 rtl/if_fetch_icache.sv | 49 ++++
 rtl/if_fetch.sv | 124 ++++++++++++
 tb/tb_if_fetch.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage definitions: bus widths, reset sense and the fetch FSM encoding.
package if_fetch_pkg;

  localparam int Addrlen = 32;
  localparam int Instlen = 32;

  localparam logic [Instlen-1:0] ZeroWord = '0;
  localparam logic ResetEnable = 1'b1;

  // Index width for the default 128-line instruction cache.
  localparam int ICacheEntriesDefault = 128;
  localparam int ICacheIndexLen = $clog2(ICacheEntriesDefault);

  typedef enum logic {
    IfIdle = 1'b0,
    IfWait = 1'b1
  } if_state_e;

endpackage

// File: rtl/if_fetch_icache.sv
// Direct-mapped instruction cache: one word per line, combinational read, one synchronous write port.
module if_fetch_icache
  import if_fetch_pkg::*;
#(
  parameter int Entries = 128,
  parameter int IdxW    = $clog2(Entries),
  parameter int TagW    = Addrlen - IdxW - 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IdxW-1:0]    rd_idx_i,
  input  logic [TagW-1:0]    rd_tag_i,
  output logic               hit_o,
  output logic [Instlen-1:0] rd_data_o,
  input  logic               we_i,
  input  logic [IdxW-1:0]    wr_idx_i,
  input  logic [TagW-1:0]    wr_tag_i,
  input  logic [Instlen-1:0] wr_data_i
);

  logic [Entries-1:0] valid_q;
  logic [TagW-1:0]    tag_q  [Entries];
  logic [Instlen-1:0] data_q [Entries];

  // Valid bits: cleared only by reset, set by a fill.
  always_ff @(posedge clk) begin
    if (rst == ResetEnable) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays carry no reset; the valid bits alone decide whether a line is usable.
  // Fill path for tag and data.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Zero-latency lookup.
  always_comb begin
    hit_o     = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
    rd_data_o = data_q[rd_idx_i];
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, I-cache lookup, miss handshake with the memory controller, jump redirect.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int                 ICACHE_ENTRIES = 128,
  parameter logic [Addrlen-1:0] RESET_PC       = 32'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic [5:0]         stall,
  input  logic               ifjump,
  input  logic [Addrlen-1:0] jump_addr,
  output logic [Addrlen-1:0] if_pc,
  output logic [Instlen-1:0] if_inst,
  output logic               stallreq_if,
  output logic               mem_req,
  output logic [Addrlen-1:0] mem_addr,
  input  logic               mem_done,
  input  logic [Instlen-1:0] mem_inst
);

  localparam int IdxW = $clog2(ICACHE_ENTRIES);
  localparam int TagW = Addrlen - IdxW - 2;

  if_state_e          state_q, state_d;
  logic [Addrlen-1:0] pc_q, pc_d;
  logic [Addrlen-1:0] mem_addr_q, mem_addr_d;
  logic               mem_req_q, mem_req_d;
  // Set when a jump lands while a fill is in flight: the returning word belongs to
  // mem_addr, not pc, so it is only written to the cache and pc is looked up afresh.
  logic               discard_q, discard_d;

  logic               hit;
  logic [Instlen-1:0] line_data;
  logic               fill_we;
  logic               busy;

  // Only the hold-PC bit of the stall vector matters to fetch.
  logic stall_unused;
  assign stall_unused = ^stall[5:1];

  if_fetch_icache #(
    .Entries (ICACHE_ENTRIES)
  ) u_icache (
    .clk       (clk),
    .rst       (rst),
    .rd_idx_i  (pc_q[IdxW+1:2]),
    .rd_tag_i  (pc_q[Addrlen-1:IdxW+2]),
    .hit_o     (hit),
    .rd_data_o (line_data),
    .we_i      (fill_we),
    .wr_idx_i  (mem_addr_q[IdxW+1:2]),
    .wr_tag_i  (mem_addr_q[Addrlen-1:IdxW+2]),
    .wr_data_i (mem_inst)
  );

  // Next-state, fill control and PC update; rdy low freezes everything.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    discard_d  = discard_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fill_we    = 1'b0;
    busy       = (state_q == IfWait) || !hit;

    if (rdy) begin
      case (state_q)
        IfIdle: begin
          // A jump on a miss cycle re-targets before any request is issued.
          if (!hit && !ifjump) begin
            state_d    = IfWait;
            mem_req_d  = 1'b1;
            mem_addr_d = pc_q;
          end
        end
        IfWait: begin
          if (mem_done) begin
            fill_we   = 1'b1;
            state_d   = IfIdle;
            mem_req_d = 1'b0;
            discard_d = 1'b0;
          end else if (ifjump) begin
            discard_d = 1'b1;
          end
        end
        default: state_d = IfIdle;
      endcase

      if (ifjump) begin
        pc_d = jump_addr;
      end else if (!stall[0] && !busy) begin
        pc_d = pc_q + Addrlen'(4);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register samples the pre-edge values of the others.
    if (rst == ResetEnable) begin
      state_q    <= IfIdle;
      pc_q       <= RESET_PC;
      discard_q  <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      discard_q  <= discard_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign if_pc       = pc_q;
  assign stallreq_if = busy;
  assign if_inst     = busy ? ZeroWord : line_data;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: memory responder, address-level cache model, per-cycle compare.
module tb_if_fetch;

  localparam int ENTRIES = 128;
  localparam int LAT     = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [5:0]  stall;
  logic        ifjump;
  logic [31:0] jump_addr;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_inst;

  int n_checks = 0;
  int n_fail   = 0;
  int seen_40  = 0;

  if_fetch #(
    .ICACHE_ENTRIES (ENTRIES),
    .RESET_PC       (32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .stall       (stall),
    .ifjump      (ifjump),
    .jump_addr   (jump_addr),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .stallreq_if (stallreq_if),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_done    (mem_done),
    .mem_inst    (mem_inst)
  );

  always #5 clk = ~clk;

  // Memory image: each word is derived from its own address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model: which addresses are resident, what is outstanding
  bit          model_on = 1'b0;
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  bit          m_pend;
  bit          m_ok   [ENTRIES];
  logic [31:0] m_line [ENTRIES];

  function automatic bit resident(input logic [31:0] a);
    int idx;
    idx = int'((a >> 2) % ENTRIES);
    return m_ok[idx] && (m_line[idx] == a);
  endfunction

  initial begin : model
    bit busy;
    int idx;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_pc   = 32'h0;
        m_addr = 32'h0;
        m_pend = 1'b0;
        foreach (m_ok[i]) m_ok[i] = 1'b0;
        model_on = 1'b1;
      end else if (model_on && rdy) begin
        busy = m_pend || !resident(m_pc);
        if (m_pend) begin
          if (mem_done) begin
            idx = int'((m_addr >> 2) % ENTRIES);
            m_ok[idx]   = 1'b1;
            m_line[idx] = m_addr;
            m_pend      = 1'b0;
          end
        end else if (busy && !ifjump) begin
          m_pend = 1'b1;
          m_addr = m_pc;
        end
        if (ifjump) m_pc = jump_addr;
        else if (!stall[0] && !busy) m_pc = m_pc + 32'd4;
      end
    end
  end

  // ---------------- per-cycle compare, away from the active edge
  initial begin : compare
    bit exp_stall;
    forever begin
      @(negedge clk);
      if (model_on) begin
        exp_stall = m_pend || !resident(m_pc);
        check("if_pc", if_pc, m_pc);
        check("stallreq_if", {31'b0, stallreq_if}, {31'b0, exp_stall});
        check("if_inst", if_inst, exp_stall ? 32'h0 : word_at(m_pc));
        check("mem_req", {31'b0, mem_req}, {31'b0, m_pend});
        check("mem_addr", mem_addr, m_addr);
        if (!stallreq_if && if_inst == word_at(32'h40)) seen_40++;
      end
    end
  end

  // ---------------- memory responder: LAT cycles after request, holds done until consumed
  bit took;
  bit was_rst;
  int cnt;
  initial begin : responder
    mem_done = 1'b0;
    mem_inst = 32'h0;
    cnt      = 0;
    forever begin
      @(posedge clk);
      took    = mem_done && rdy && !rst;
      was_rst = rst;
      assert (rst || !mem_done || mem_req)
        else $error("protocol error: mem_done while no request outstanding");
      @(negedge clk);
      if (was_rst || took) begin
        mem_done = 1'b0;
        cnt      = 0;
      end else if (!mem_done && mem_req) begin
        cnt++;
        if (cnt >= LAT) begin
          mem_done = 1'b1;
          mem_inst = word_at(mem_addr);
        end
      end
    end
  end

  // Wait until the given PC is delivered on a hit, bounded.
  task automatic wait_hit(input string name, input logic [31:0] pc, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (if_pc == pc && !stallreq_if) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check(name, {31'b0, ok}, 32'd1);
  endtask

  task automatic jump_to(input logic [31:0] a);
    ifjump    = 1'b1;
    jump_addr = a;
    tick();
    ifjump    = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed stimulus
  initial begin : stim
    int  n;
    bit  found;
    rst       = 1'b1;
    rdy       = 1'b1;
    stall     = 6'b0;
    ifjump    = 1'b0;
    jump_addr = 32'h0;
    tick();
    tick();
    rst = 1'b0;

    // Cold start: cycle 0 misses, request visible in cycle 1.
    check("cold_c0_stall", {31'b0, stallreq_if}, 32'd1);
    check("cold_c0_req", {31'b0, mem_req}, 32'd0);
    tick();
    check("cold_c1_req", {31'b0, mem_req}, 32'd1);
    check("cold_c1_addr", mem_addr, 32'h0);
    n = 0;
    while (stallreq_if && n < 20) begin
      tick();
      n++;
    end
    check("cold_latency", n, 32'd4);
    check("cold_inst", if_inst, 32'h0000_FFFF);
    check("cold_pc", if_pc, 32'h0);
    tick();
    check("cold_next_pc", if_pc, 32'h4);

    // Warm loop: fill 0x4..0xC, jump back to 0 from the hit at 0xC.
    wait_hit("wait_0c", 32'hC, 60);
    jump_to(32'h0);
    for (int i = 0; i < 4; i++) begin
      check("warm_pc", if_pc, 32'(i * 4));
      check("warm_stall", {31'b0, stallreq_if}, 32'd0);
      check("warm_req", {31'b0, mem_req}, 32'd0);
      if (i == 3) begin
        ifjump    = 1'b1;
        jump_addr = 32'h40;
      end
      tick();
    end
    ifjump = 1'b0;

    // Jump mid-miss: miss at 0x40, redirect to 0x100 two cycles later.
    check("mid_miss_stall", {31'b0, stallreq_if}, 32'd1);
    tick();
    check("mid_req_40", mem_addr, 32'h40);
    tick();
    jump_to(32'h100);
    check("mid_addr_held", mem_addr, 32'h40);
    check("mid_pc_new", if_pc, 32'h100);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req && mem_addr == 32'h100) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("mid_req_100", {31'b0, found}, 32'd1);
    wait_hit("wait_100", 32'h100, 20);
    check("mid_inst_100", if_inst, 32'h0100_FEFF);
    check("mid_never_40", seen_40, 32'd0);
    jump_to(32'h40);
    check("line40_hit", {31'b0, stallreq_if}, 32'd0);
    check("line40_inst", if_inst, 32'h0040_FFBF);

    // stall[0] on a hit holds pc for three cycles.
    stall = 6'b000001;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold_pc", if_pc, 32'h40);
    end
    stall = 6'b0;
    tick();
    check("stall_release_pc", if_pc, 32'h44);

    // rdy low while mem_done is present: done ignored, request held.
    tick();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #2;
      if (mem_done) begin
        found = 1'b1;
        break;
      end
    end
    check("rdy_saw_done", {31'b0, found}, 32'd1);
    rdy = 1'b0;
    tick();
    rdy = 1'b1;
    check("rdy_req_held", {31'b0, mem_req}, 32'd1);
    check("rdy_still_stall", {31'b0, stallreq_if}, 32'd1);
    tick();
    check("rdy_then_hit", {31'b0, stallreq_if}, 32'd0);
    check("rdy_inst_44", if_inst, 32'h0044_FFBB);

    // Conflict: 0x200 maps onto the line of 0x000 and evicts it.
    jump_to(32'h200);
    check("conf_200_miss", {31'b0, stallreq_if}, 32'd1);
    wait_hit("wait_200", 32'h200, 20);
    check("conf_inst_200", if_inst, 32'h0200_FDFF);
    jump_to(32'h0);
    check("conf_0_miss", {31'b0, stallreq_if}, 32'd1);
    tick();
    check("conf_0_req", {31'b0, mem_req}, 32'd1);

    // Reset during WAIT.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_req", {31'b0, mem_req}, 32'd0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_stall", {31'b0, stallreq_if}, 32'd1);
    wait_hit("wait_rst_0", 32'h0, 20);
    jump_to(32'h200);
    check("rst_200_miss", {31'b0, stallreq_if}, 32'd1);
    wait_hit("wait_rst_200", 32'h200, 20);

    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
